// File: rtl/mod_pkg.sv
// Shared definitions for the mod-unit arbiter.
//   mod_state_e     : arbiter FSM encoding (IDLE -> LAUNCH -> WAIT -> RESP)
//   MOD_*_DEF       : default requester count, operand width and watchdog limit
package mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } mod_state_e;

  localparam int MOD_NREQ_DEF    = 4;
  localparam int MOD_W_DEF       = 32;
  localparam int MOD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i          : request vector
//   rr_ptr_i       : highest-priority slot for this pick (< NREQ)
//   grant_valid_o  : some request is pending
//   grant_idx_o    : first set req bit at or after rr_ptr_i, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            grant_valid_o,
  output logic [IW-1:0]   grant_idx_o
);

  localparam int SW = IW + 1;

  logic [SW-1:0] slot;

  // Scan offsets from the farthest back to the pointer, so the set bit closest
  // to rr_ptr_i (in wrap order) is the last one written and wins.
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = '0;
    slot          = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_ptr_i} + SW'(k);
      if (slot >= SW'(NREQ)) slot = slot - SW'(NREQ);
      if (req_i[slot[IW-1:0]]) grant_idx_o = slot[IW-1:0];
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// Shares one iterative mod unit among NREQ requesters in round-robin order.
// A grant registers the owner's operands, fires a 1-cycle gen pulse, waits
// for gen_end (bounded by a watchdog) and returns the result with a one-hot
// done pulse. Zero divisors are rejected without touching the unit.
//   clk, rst                  : clock, synchronous active-high reset
//   req / req_dividend / req_divisor : per-requester level + flattened operands
//   done / resp_res / resp_err       : one-hot completion pulse, result, error flag
//   mod_gen / mod_dividend / mod_divisor : start pulse + operands to the mod unit
//   mod_gen_end / mod_res            : completion + result from the mod unit
module mod_arbiter
  import mod_pkg::*;
#(
  parameter int NREQ    = MOD_NREQ_DEF,
  parameter int W       = MOD_W_DEF,
  parameter int TIMEOUT = MOD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      resp_res,
  output logic              resp_err,
  output logic              mod_gen,
  output logic [W-1:0]      mod_dividend,
  output logic [W-1:0]      mod_divisor,
  input  logic              mod_gen_end,
  input  logic [W-1:0]      mod_res
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  mod_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    resp_res_q, resp_res_d;
  logic            resp_err_q, resp_err_d;
  logic            mod_gen_q, mod_gen_d;
  logic [W-1:0]    mod_dividend_q, mod_dividend_d;
  logic [W-1:0]    mod_divisor_q, mod_divisor_d;

  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [W-1:0]    gnt_dividend;
  logic [W-1:0]    gnt_divisor;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i         (req),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  assign gnt_dividend = req_dividend[grant_idx*W +: W];
  assign gnt_divisor  = req_divisor[grant_idx*W +: W];

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    wd_cnt_d       = wd_cnt_q;
    done_d         = '0;
    resp_res_d     = resp_res_q;
    resp_err_d     = resp_err_q;
    mod_gen_d      = 1'b0;
    mod_dividend_d = mod_dividend_q;
    mod_divisor_d  = mod_divisor_q;

    unique case (state_q)
      ST_IDLE: begin
        // A gen_end still high from the previous job holds off the next
        // launch, so a level-style or stale gen_end can't finish a new job.
        if (grant_valid && !mod_gen_end) begin
          owner_d        = grant_idx;
          rr_ptr_d       = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          mod_dividend_d = gnt_dividend;
          mod_divisor_d  = gnt_divisor;
          if (gnt_divisor == '0) begin
            resp_res_d        = '0;
            resp_err_d        = 1'b1;
            done_d[grant_idx] = 1'b1;
            state_d           = ST_RESP;
          end else begin
            mod_gen_d = 1'b1;
            state_d   = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (mod_gen_end) begin
          resp_res_d      = mod_res;
          resp_err_d      = 1'b0;
          done_d[owner_q] = 1'b1;
          state_d         = ST_RESP;
        end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
          resp_res_d      = '0;
          resp_err_d      = 1'b1;
          done_d[owner_q] = 1'b1;
          state_d         = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      wd_cnt_q       <= '0;
      done_q         <= '0;
      resp_res_q     <= '0;
      resp_err_q     <= 1'b0;
      mod_gen_q      <= 1'b0;
      mod_dividend_q <= '0;
      mod_divisor_q  <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      wd_cnt_q       <= wd_cnt_d;
      done_q         <= done_d;
      resp_res_q     <= resp_res_d;
      resp_err_q     <= resp_err_d;
      mod_gen_q      <= mod_gen_d;
      mod_dividend_q <= mod_dividend_d;
      mod_divisor_q  <= mod_divisor_d;
    end
  end

  assign done         = done_q;
  assign resp_res     = resp_res_q;
  assign resp_err     = resp_err_q;
  assign mod_gen      = mod_gen_q;
  assign mod_dividend = mod_dividend_q;
  assign mod_divisor  = mod_divisor_q;

endmodule

// File: tb/tb_mod_arbiter.sv
// Bench for mod_arbiter: behavioural mod unit, scoreboard of expected
// (owner, result, error) tuples popped on every done pulse.
module tb_mod_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      resp_res;
  logic              resp_err;
  logic              mod_gen;
  logic [W-1:0]      mod_dividend;
  logic [W-1:0]      mod_divisor;
  logic              mod_gen_end;
  logic [W-1:0]      mod_res;

  mod_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .done         (done),
    .resp_res     (resp_res),
    .resp_err     (resp_err),
    .mod_gen      (mod_gen),
    .mod_dividend (mod_dividend),
    .mod_divisor  (mod_divisor),
    .mod_gen_end  (mod_gen_end),
    .mod_res      (mod_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterative mod unit: a few cycles after gen, one gen_end pulse.
  // stub_hang swallows gen; force_gen_end holds gen_end high.
  logic         stub_hang = 1'b0;
  logic         force_gen_end = 1'b0;
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk) begin
    if (rst) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
      mod_gen_end <= 1'b0;
      mod_res     <= '0;
    end else begin
      mod_gen_end <= force_gen_end;
      if (m_busy) begin
        if (m_cnt == 0) begin
          mod_gen_end <= 1'b1;
          mod_res     <= m_a % m_b;
          m_busy      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (mod_gen && !stub_hang) begin
        m_busy <= 1'b1;
        m_a    <= mod_dividend;
        m_b    <= mod_divisor;
        m_cnt  <= 2 + int'(mod_dividend % 4);
      end
    end
  end

  typedef struct {
    int           idx;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   gen_cnt = 0;
  int   done_cnt = 0;
  int   last_gen_cyc = 0;
  int   last_done_cyc = 0;
  logic job_open = 1'b0;
  logic sticky = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic to);
    exp_t e;
    e.idx = i;
    e.err = (b == '0) || to;
    e.res = e.err ? '0 : a % b;
    sb.push_back(e);
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic to);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req[i]                 = 1'b1;
    push_exp(i, a, b, to);
  endtask

  // One cycle of observation at the falling edge.
  task automatic tick_mon();
    exp_t e;
    @(negedge clk);
    if (mod_gen) begin
      chk("gen_overlap", 64'(job_open), 64'd0);
      job_open     = 1'b1;
      gen_cnt++;
      last_gen_cyc = cyc;
    end
    if (done != '0) begin
      chk("done_onehot", 64'($countones(done)), 64'd1);
      done_cnt++;
      last_done_cyc = cyc;
      job_open      = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_idx", 64'(done), 64'd1 << e.idx);
        chk("resp_res", 64'(resp_res), 64'(e.res));
        chk("resp_err", 64'(resp_err), 64'(e.err));
      end
      if (!sticky) req = req & ~done;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int start;
    int k;
    start = done_cnt;
    k     = 0;
    while ((done_cnt - start) < n && k < budget) begin
      tick_mon();
      k++;
    end
    chk("done_count", 64'(done_cnt - start), 64'(n));
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_done"},     64'(done), 64'd0);
    chk({pfx, "_res"},      64'(resp_res), 64'd0);
    chk({pfx, "_err"},      64'(resp_err), 64'd0);
    chk({pfx, "_gen"},      64'(mod_gen), 64'd0);
    chk({pfx, "_dividend"}, 64'(mod_dividend), 64'd0);
    chk({pfx, "_divisor"},  64'(mod_divisor), 64'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    job_open = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero("rst");
    rst = 1'b0;
  endtask

  initial begin
    int d, g0;
    rst          = 1'b1;
    req          = '0;
    req_dividend = '0;
    req_divisor  = '0;

    // 1: single request
    do_reset();
    d  = cyc;
    g0 = gen_cnt;
    issue(0, 100, 10, 1'b0);
    wait_done(1, 60);
    chk("t1_gen_lat", 64'(last_gen_cyc - d), 64'd1);
    chk("t1_gen_cnt", 64'(gen_cnt - g0), 64'd1);
    chk("t1_req_clr", 64'(req), 64'd0);

    // 2: contention, simultaneous raise -> 0,1,2
    do_reset();
    g0 = gen_cnt;
    issue(0, 123, 7, 1'b0);
    issue(1, 25, 4, 1'b0);
    issue(2, 999, 1, 1'b0);
    wait_done(3, 150);
    chk("t2_gen_cnt", 64'(gen_cnt - g0), 64'd3);

    // 3: fairness with all requests held
    do_reset();
    sticky = 1'b1;
    for (int i = 0; i < NREQ; i++) issue(i, W'(100 + 37 * i), W'(3 + i), 1'b0);
    for (int i = 0; i < NREQ; i++) push_exp(i, W'(100 + 37 * i), W'(3 + i), 1'b0);
    wait_done(8, 300);
    req    = '0;
    sticky = 1'b0;
    tick_mon();

    // 4: divide-by-zero
    d  = cyc;
    g0 = gen_cnt;
    issue(1, 50, 0, 1'b0);
    wait_done(1, 20);
    chk("t4_done_lat", 64'(last_done_cyc - d), 64'd1);
    chk("t4_no_gen", 64'(gen_cnt - g0), 64'd0);

    // 5: watchdog timeout, then launch blocked while gen_end is high
    do_reset();
    stub_hang = 1'b1;
    issue(3, 77, 5, 1'b1);
    wait_done(1, TIMEOUT + 20);
    chk("t5_to_lat", 64'(last_done_cyc - last_gen_cyc), 64'(TIMEOUT + 1));
    force_gen_end = 1'b1;
    stub_hang     = 1'b0;
    g0            = gen_cnt;
    issue(2, 60, 7, 1'b0);
    for (int k = 0; k < 6; k++) tick_mon();
    chk("t5_blocked_gen", 64'(gen_cnt - g0), 64'd0);
    chk("t5_blocked_sb", 64'(sb.size()), 64'd1);
    force_gen_end = 1'b0;
    wait_done(1, 60);
    chk("t5_gen_after", 64'(gen_cnt - g0), 64'd1);

    // 6: reset in WAIT abandons the job
    do_reset();
    stub_hang = 1'b1;
    req_dividend[0 +: W] = 123;
    req_divisor[0 +: W]  = 7;
    req[0] = 1'b1;
    g0 = gen_cnt;
    for (int k = 0; k < 20 && gen_cnt == g0; k++) tick_mon();
    chk("t6_launched", 64'(gen_cnt - g0), 64'd1);
    for (int k = 0; k < 3; k++) tick_mon();
    chk("t6_in_wait_dividend", 64'(mod_dividend), 64'd123);
    rst    = 1'b1;
    req    = '0;
    @(negedge clk);
    chk_outputs_zero("t6_rst");
    rst       = 1'b0;
    stub_hang = 1'b0;
    job_open  = 1'b0;
    for (int k = 0; k < 3; k++) tick_mon();
    issue(0, 123, 7, 1'b0);
    wait_done(1, 60);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "bench time limit");
  end

endmodule
